// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : MEM-stage load/store sequencer. Drives a req/ack data RAM port
//            with byte enables, stalls the upstream pipeline until the RAM
//            answers, and hands an aligned, extended load word plus the
//            RAM/ALU select to the MEM/WB latch. Misaligned or illegal
//            accesses and RAM timeouts raise a one-cycle fault pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memReadIn,
  input  logic              memWriteIn,
  input  logic [2:0]        funct3In,
  input  logic [DATA_W-1:0] addrIn,
  input  logic [DATA_W-1:0] storeDataIn,
  input  logic              regWriteEnableIn,
  output logic              stall,
  output logic              select,
  output logic [DATA_W-1:0] loadData,
  output logic              regWriteEnableOut,
  output logic              fault,
  output logic              ram_req,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata
);

  // The counter must be able to hold TIMEOUT-1, the last BUSY cycle index.
  localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  // Lane handling below is written for a 32-bit, 4-byte-lane data path.
  if (DATA_W != 32 || REG_AW < 1 || TIMEOUT < 1) begin : g_param_check
    $error("mem_access_ctrl: unsupported parameter set");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_is_load;
  logic [2:0]         r_funct3;
  logic [1:0]         r_off;
  logic               r_fault;
  logic [DATA_W-1:0]  r_load_data;
  logic               r_ram_req;
  logic               r_ram_we;
  logic [DATA_W-1:0]  r_ram_addr;
  logic [DATA_W-1:0]  r_ram_wdata;
  logic [3:0]         r_ram_be;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic              w_memop;
  logic              w_is_load;
  logic              w_f3_ok;
  logic              w_aligned;
  logic              w_access_ok;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;

  // Classify the incoming access and build its byte enables / lane data.
  always_comb begin
    w_memop   = memReadIn | memWriteIn;
    // A simultaneous read and write is handled as a load.
    w_is_load = memReadIn;

    if (w_is_load) begin
      w_f3_ok = (funct3In == 3'b000) || (funct3In == 3'b001) ||
                (funct3In == 3'b010) || (funct3In == 3'b100) ||
                (funct3In == 3'b101);
    end else begin
      w_f3_ok = (funct3In == 3'b000) || (funct3In == 3'b001) ||
                (funct3In == 3'b010);
    end

    // funct3[1:0] encodes the access size for both loads and stores.
    case (funct3In[1:0])
      2'b00: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << addrIn[1:0];
        w_wdata   = {4{storeDataIn[7:0]}};
      end
      2'b01: begin
        w_aligned = ~addrIn[0];
        w_be      = addrIn[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{storeDataIn[15:0]}};
      end
      default: begin
        w_aligned = (addrIn[1:0] == 2'b00);
        w_be      = 4'b1111;
        w_wdata   = storeDataIn;
      end
    endcase

    w_access_ok = w_f3_ok && w_aligned;
  end

  // --------------------------------------------------------------------------
  // Load extraction from the returned RAM word
  // --------------------------------------------------------------------------
  logic [7:0]        w_lane_byte;
  logic [15:0]       w_lane_half;
  logic [DATA_W-1:0] w_ext;

  // Pick the addressed byte/halfword of ram_rdata and sign/zero extend it.
  always_comb begin
    w_lane_byte = ram_rdata[{r_off, 3'b000} +: 8];
    w_lane_half = r_off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ext = {{24{w_lane_byte[7]}}, w_lane_byte};
      3'b001:  w_ext = {{16{w_lane_half[15]}}, w_lane_half};
      3'b100:  w_ext = {24'd0, w_lane_byte};
      3'b101:  w_ext = {16'd0, w_lane_half};
      default: w_ext = ram_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  // IDLE launches or rejects an access, BUSY waits for ack or timeout, DONE
  // releases the pipeline for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_cnt       <= '0;
      r_is_load   <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_fault     <= 1'b0;
      r_load_data <= '0;
      r_ram_req   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_be    <= 4'b0000;
    end else begin
      // The fault flag is only ever set on entry to DONE, so it lasts one cycle.
      r_fault <= 1'b0;

      case (r_state)
        c_IDLE: begin
          r_cnt <= '0;
          if (w_memop) begin
            if (w_access_ok) begin
              r_ram_req   <= 1'b1;
              r_ram_we    <= ~w_is_load;
              r_ram_addr  <= {addrIn[DATA_W-1:2], 2'b00};
              r_ram_be    <= w_be;
              r_ram_wdata <= w_wdata;
              r_is_load   <= w_is_load;
              r_funct3    <= funct3In;
              r_off       <= addrIn[1:0];
              r_state     <= c_BUSY;
            end else begin
              // Rejected access: the RAM port is left untouched.
              r_fault     <= 1'b1;
              r_load_data <= '0;
              r_state     <= c_DONE;
            end
          end
        end

        c_BUSY: begin
          // Ack is checked first so that an ack on the final cycle still wins.
          if (ram_ack) begin
            if (r_is_load) begin
              r_load_data <= w_ext;
            end
            r_ram_req <= 1'b0;
            r_state   <= c_DONE;
          end else if (r_cnt == c_CNT_LAST) begin
            r_ram_req   <= 1'b0;
            r_load_data <= '0;
            r_fault     <= 1'b1;
            r_state     <= c_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        c_DONE: begin
          r_cnt   <= '0;
          r_state <= c_IDLE;
        end

        default: begin
          r_cnt     <= '0;
          r_ram_req <= 1'b0;
          r_state   <= c_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Pipeline handshake: hold upstream until DONE; bubbles carry no write.
  always_comb begin
    stall             = w_memop && (r_state != c_DONE);
    select            = memReadIn && (r_state == c_DONE);
    regWriteEnableOut = regWriteEnableIn && !stall && !r_fault;
  end

  assign fault     = r_fault;
  assign loadData  = r_load_data;
  assign ram_req   = r_ram_req;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_be    = r_ram_be;

endmodule
`default_nettype wire
